// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared 64-bit ALU: request handshake, one EXEC cycle, registered response.
// Latency is handshake edge N, resp_valid in cycle N+2. Requests are refused outside IDLE, and RESP holds until the owner takes the response.
module alu_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    input  logic [3:0]  req0_op,
    input  logic [3:0]  req1_op,
    input  logic [2:0]  req0_funct3,
    input  logic [2:0]  req1_funct3,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic [3:0]  alu_op,
    output logic [2:0]  alu_funct3,
    input  logic [63:0] alu_result,
    input  logic        alu_zero,
    output logic [1:0]  resp_valid,
    input  logic [1:0]  resp_ready,
    output logic [63:0] resp_result,
    output logic        resp_zero,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_owner;
    logic        r_last_grant;
    logic [63:0] r_a;
    logic [63:0] r_b;
    logic [3:0]  r_op;
    logic [2:0]  r_funct3;
    logic [63:0] r_resp_result;
    logic        r_resp_zero;
    logic        w_grant_id;
    logic        w_hs;

    // On a tie the requester that did not win last time goes next.
    assign w_grant_id = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 2'b00;
        resp_valid  = 2'b00;
        w_hs        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid != 2'b00) begin
                    req_ready   = w_grant_id ? 2'b10 : 2'b01;
                    w_hs        = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = r_owner ? 2'b10 : 2'b01;
                if (resp_ready[r_owner]) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_owner       <= 1'b0;
            r_last_grant  <= 1'b1;
            r_a           <= '0;
            r_b           <= '0;
            r_op          <= '0;
            r_funct3      <= '0;
            r_resp_result <= '0;
            r_resp_zero   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs) begin
                r_owner      <= w_grant_id;
                r_last_grant <= w_grant_id;
                r_a          <= w_grant_id ? req1_a      : req0_a;
                r_b          <= w_grant_id ? req1_b      : req0_b;
                r_op         <= w_grant_id ? req1_op     : req0_op;
                r_funct3     <= w_grant_id ? req1_funct3 : req0_funct3;
            end
            if (r_state == ST_EXEC) begin
                r_resp_result <= alu_result;
                r_resp_zero   <= alu_zero;
            end
        end
    end

    assign alu_a       = r_a;
    assign alu_b       = r_b;
    assign alu_op      = r_op;
    assign alu_funct3  = r_funct3;
    assign resp_result = r_resp_result;
    assign resp_zero   = r_resp_zero;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU on the shared port, plus a scoreboard that predicts each response at handshake time.
module tb_alu_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic [2:0]  req0_funct3, req1_funct3;
    logic [63:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [2:0]  alu_funct3;
    logic [63:0] alu_result;
    logic        alu_zero;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [63:0] resp_result;
    logic        resp_zero;
    logic        busy;

    typedef struct packed {
        logic        id;
        logic [63:0] res;
        logic        zero;
    } exp_t;

    exp_t        q[$];
    logic        gl[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          hs_cyc = 0;
    logic        awaiting = 1'b0;
    logic        exp_last_grant = 1'b1;
    logic [63:0] last_res = '0;
    logic        last_zero = 1'b0;

    alu_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_funct3(req0_funct3), .req1_funct3(req1_funct3),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_funct3(alu_funct3),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_zero(resp_zero), .busy(busy)
    );

    function automatic logic [63:0] f_alu(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b1000: return a << b[5:0];
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic f_zero(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                                    input logic [2:0] f3);
        logic [63:0] r;
        r = f_alu(a, b, op);
        case (f3)
            3'b000:  return (r == 64'd0);
            3'b001:  return (r != 64'd0);
            3'b100:  return ($signed(a) <  $signed(b));
            3'b101:  return ($signed(a) >= $signed(b));
            3'b110:  return (a <  b);
            3'b111:  return (a >= b);
            default: return 1'b0;
        endcase
    endfunction

    assign alu_result = f_alu(alu_a, alu_b, alu_op);
    assign alu_zero   = f_zero(alu_a, alu_b, alu_op, alu_funct3);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: predict at the handshake, compare when the owner accepts the response.
    always @(negedge clk) begin
        exp_t e;
        logic id;
        cyc++;
        if (reset) begin
            q.delete();
            exp_last_grant = 1'b1;
            awaiting       = 1'b0;
        end else begin
            if (resp_valid != 2'b00) begin
                if (awaiting) begin
                    chk("latency", 64'(cyc - hs_cyc), 64'd2);
                    awaiting = 1'b0;
                end
                if (q.size() == 0) begin
                    chk("spurious_resp", 64'(resp_valid), 64'd0);
                end else begin
                    chk("resp_owner", 64'(resp_valid), q[0].id ? 64'd2 : 64'd1);
                    if ((resp_valid & resp_ready) != 2'b00) begin
                        e = q.pop_front();
                        chk("resp_result", resp_result, e.res);
                        chk("resp_zero", 64'(resp_zero), 64'(e.zero));
                        last_res  = resp_result;
                        last_zero = resp_zero;
                    end
                end
            end
            if ((req_valid & req_ready) != 2'b00) begin
                id = (req_valid == 2'b11) ? ~exp_last_grant : req_valid[1];
                chk("grant", 64'(req_ready), id ? 64'd2 : 64'd1);
                e.id = id;
                if (id) begin
                    e.res  = f_alu(req1_a, req1_b, req1_op);
                    e.zero = f_zero(req1_a, req1_b, req1_op, req1_funct3);
                end else begin
                    e.res  = f_alu(req0_a, req0_b, req0_op);
                    e.zero = f_zero(req0_a, req0_b, req0_op, req0_funct3);
                end
                q.push_back(e);
                gl.push_back(id);
                exp_last_grant = id;
                hs_cyc         = cyc;
                awaiting       = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set0(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op, input logic [2:0] f3);
        req0_a = a; req0_b = b; req0_op = op; req0_funct3 = f3;
    endtask

    task automatic set1(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op, input logic [2:0] f3);
        req1_a = a; req1_b = b; req1_op = op; req1_funct3 = f3;
    endtask

    // Holds each valid bit until its handshake; returns in the cycle after the last one.
    task automatic serve(input int max);
        int n;
        logic [1:0] drop;
        n = 0;
        while (req_valid != 2'b00 && n < max) begin
            @(negedge clk);
            drop = req_valid & req_ready;
            step();
            req_valid = req_valid & ~drop;
            n++;
        end
        if (req_valid != 2'b00) begin
            chk("serve_timeout", 64'(req_valid), 64'd0);
            req_valid = 2'b00;
        end
    endtask

    task automatic wait_resp(input int max);
        int n;
        n = 0;
        while (q.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("resp_timeout", 64'(q.size()), 64'd0);
    endtask

    initial begin
        reset = 1'b1; req_valid = 2'b00; resp_ready = 2'b11;
        set0(0, 0, 0, 0); set1(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_result", resp_result, 64'd0);
        chk("rst_zero", 64'(resp_zero), 64'd0);
        chk("rst_alu_a", alu_a, 64'd0);
        chk("rst_alu_op", 64'(alu_op), 64'd0);
        chk("rst_alu_f3", 64'(alu_funct3), 64'd0);
        step();
        reset = 1'b0;

        // V1: single add from requester 0
        set0(64'd5, 64'd7, 4'b0010, 3'b000);
        req_valid = 2'b01;
        serve(20);
        @(negedge clk);
        chk("v1_alu_op", 64'(alu_op), 64'd2);
        chk("v1_alu_a", alu_a, 64'd5);
        chk("v1_busy", 64'(busy), 64'd1);
        chk("v1_no_resp_in_exec", 64'(resp_valid), 64'd0);
        wait_resp(20);
        chk("v1_result", last_res, 64'd12);
        chk("v1_zero", 64'(last_zero), 64'd0);

        // V2: tie after reset, then another tie
        step(); reset = 1'b1; step(); reset = 1'b0;
        gl.delete();
        set0(64'd9, 64'd9, 4'b0110, 3'b000);
        set1(64'hF0, 64'h0F, 4'b0001, 3'b000);
        req_valid = 2'b11;
        serve(30);
        wait_resp(20);
        chk("v2_req1_result", last_res, 64'hFF);
        set0(64'd1, 64'd2, 4'b0010, 3'b000);
        set1(64'd3, 64'd4, 4'b0010, 3'b000);
        step();
        req_valid = 2'b11;
        serve(30);
        wait_resp(20);
        chk("v2_grants", 64'(gl.size()), 64'd4);
        if (gl.size() >= 4) begin
            chk("v2_first", 64'(gl[0]), 64'd0);
            chk("v2_second", 64'(gl[1]), 64'd1);
            chk("v2_next_tie", 64'(gl[2]), 64'd0);
        end

        // V3: response held while resp_ready is low
        step();
        resp_ready = 2'b00;
        set1(64'd3, 64'd5, 4'b0110, 3'b100);
        req_valid = 2'b10;
        serve(20);
        req_valid = 2'b11;
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("v3_resp_valid", 64'(resp_valid), 64'd2);
            chk("v3_result", resp_result, 64'hFFFF_FFFF_FFFF_FFFE);
            chk("v3_zero", 64'(resp_zero), 64'd1);
            chk("v3_req_ready", 64'(req_ready), 64'd0);
            chk("v3_busy", 64'(busy), 64'd1);
        end
        step();
        req_valid = 2'b00;
        resp_ready = 2'b11;
        wait_resp(20);

        // V4: shift to the top bit
        step();
        set0(64'd1, 64'd63, 4'b1000, 3'b000);
        req_valid = 2'b01;
        serve(20);
        wait_resp(20);
        chk("v4_result", last_res, 64'h8000_0000_0000_0000);
        chk("v4_zero", 64'(last_zero), 64'd0);

        // V5: reset during EXEC, with a request held across the reset
        step();
        set0(64'd1, 64'd1, 4'b0010, 3'b000);
        req_valid = 2'b01;
        serve(20);
        reset = 1'b1;
        req_valid = 2'b01;
        step();
        @(negedge clk);
        chk("v5_idle_busy", 64'(busy), 64'd0);
        chk("v5_idle_resp", 64'(resp_valid), 64'd0);
        step();
        reset = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        chk("v5_no_hs_in_reset", 64'(busy), 64'd0);
        repeat (4) begin
            @(negedge clk);
            chk("v5_no_resp", 64'(resp_valid), 64'd0);
        end
        gl.delete();
        step();
        set0(64'd6, 64'd3, 4'b0000, 3'b001);
        set1(64'd6, 64'd3, 4'b0001, 3'b000);
        req_valid = 2'b11;
        serve(30);
        wait_resp(20);
        chk("v5_tie_grants", 64'(gl.size()), 64'd2);
        if (gl.size() >= 1) chk("v5_tie_req0", 64'(gl[0]), 64'd0);

        // V6: non-owner ready is ignored
        step();
        resp_ready = 2'b10;
        set0(64'd2, 64'd3, 4'b0010, 3'b000);
        req_valid = 2'b01;
        serve(20);
        @(negedge clk);
        repeat (4) begin
            @(negedge clk);
            chk("v6_resp_held", 64'(resp_valid), 64'd1);
            chk("v6_busy", 64'(busy), 64'd1);
        end
        step();
        resp_ready = 2'b01;
        wait_resp(20);
        step();
        @(negedge clk);
        chk("v6_idle", 64'(busy), 64'd0);

        // Random traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            step();
            set0({$urandom, $urandom}, {26'd0, 6'($urandom), $urandom}, 4'($urandom_range(0, 15)), 3'($urandom));
            set1({$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom_range(0, 15)), 3'($urandom));
            req_valid  = 2'($urandom);
            resp_ready = 2'($urandom);
        end
        step();
        req_valid  = 2'b00;
        resp_ready = 2'b11;
        wait_resp(20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and use a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  2  per-requester operation request, bit i = requester i.
REQ-005 req_ready  output  2  per-requester accept; a handshake occurs when req_valid[i] and req_ready[i] are both 1 at a clock edge.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  64 each  operands per requester.
REQ-007 req0_op, req1_op  input  4 each  ALU operation code per requester.
REQ-008 req0_funct3, req1_funct3  input  3 each  ZERO-flag condition select per requester.
REQ-009 alu_a, alu_b  output  64 each  operands to the shared ALU.
REQ-010 alu_op  output  4  operation code to the shared ALU.
REQ-011 alu_funct3  output  3  condition select to the shared ALU.
REQ-012 alu_result  input  64  combinational result from the shared ALU.
REQ-013 alu_zero  input  1  combinational ZERO flag from the shared ALU.
REQ-014 resp_valid  output  2  one-hot response valid for the owning requester.
REQ-015 resp_ready  input  2  response accept; only the bit of the owning requester is used.
REQ-016 resp_result  output  64  registered ALU result.
REQ-017 resp_zero  output  1  registered ZERO flag.
REQ-018 busy  output  1  high whenever the state is not IDLE.

Function
REQ-019 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-020 In IDLE, grant selection SHALL work as follows:
- only one req_valid bit set: grant that requester;
- both set: grant the requester that is not last_grant (round-robin);
- neither set: no grant.
REQ-021 In IDLE, req_ready SHALL be one-hot on the granted requester, combinationally; outside IDLE, req_ready SHALL be 2'b00.
REQ-022 On a handshake, the block SHALL do the following and move to EXEC:
- latch the granted requester's a, b, op and funct3;
- record the requester id as owner;
- set last_grant to that id.
REQ-023 alu_a, alu_b, alu_op and alu_funct3 SHALL be driven from the latched registers at all times, so they stay stable through EXEC and RESP.
REQ-024 EXEC SHALL last exactly one cycle; at its end, alu_result and alu_zero SHALL be captured into resp_result and resp_zero, and the FSM SHALL move to RESP.
REQ-025 In RESP, resp_valid[owner] SHALL be 1 and the other bit 0.
REQ-026 In RESP, resp_result and resp_zero SHALL be held stable until resp_ready[owner] is 1.
REQ-027 When resp_ready[owner] is 1 in RESP, the FSM SHALL return to IDLE; resp_ready of the non-owner SHALL be ignored.
REQ-028 Latency SHALL be: handshake at edge N, EXEC during cycle N+1, resp_valid asserted during cycle N+2; peak throughput is one operation per 3 cycles.
REQ-029 In IDLE, resp_valid SHALL be 2'b00.
REQ-030 New requests SHALL NOT be accepted during EXEC or RESP.
REQ-031 Requester inputs SHALL NOT be sampled after the handshake.
REQ-032 op codes SHALL be passed through unchecked; an unsupported code returns whatever the ALU produces (0 for the current ALU).
REQ-033 last_grant SHALL change only on a handshake.
REQ-034 A requester dropping req_valid before a handshake SHALL cause no state change.

Reset
REQ-035 On reset, the block SHALL set:
- state = IDLE, owner = 0, last_grant = 1 (requester 0 wins the first tie);
- latched operands, op and funct3 = 0;
- resp_result = 0, resp_zero = 0, resp_valid = 0, busy = 0.
REQ-036 Reset asserted in EXEC or RESP SHALL abort the transaction with no response issued, and the next cycle SHALL be IDLE.
REQ-037 Reset SHALL take priority over all handshakes in the same cycle.

Verification
REQ-038 The bench SHALL cover these directed scenarios:
- V1: req0 only, a=5, b=7, op=0010, funct3=000, resp_ready=11 -> alu_op=0010 in EXEC; resp_valid=01 two cycles after the handshake; resp_result=12; resp_zero=0.
- V2: after reset, both requesters valid; req0 op=0110 a=9 b=9 funct3=000; req1 op=0001 a=0xF0 b=0x0F -> req0 served first (result 0, zero 1); req1 served next (result 0xFF); the next tie grants req0.
- V3: req1 op=0110 a=3 b=5 funct3=100, resp_ready=00 for 5 cycles -> resp_valid=10 held; resp_result=0xFFFFFFFFFFFFFFFE and resp_zero=1 stable; req_ready=00; busy=1.
- V4: req0 op=1000 a=1 b=63 -> resp_result=0x8000000000000000, resp_zero=0 (funct3=000).
- V5: reset pulsed during EXEC -> next cycle IDLE; resp_valid never asserts; a subsequent tie grants req0.
- V6: resp_ready=10 while owner is 0 -> remains in RESP until resp_ready[0]=1.
